// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: sequencer for the 2-lane radix-2^2 SDF FFT datapath.
// Generates the datapath advance strobe, BFII feedback-mux select, both twiddle
// ROM address/enable streams, and output valid/frame markers including the
// zero-stuffed drain of the pipeline at end of stream.
`timescale 1ns/1ps
module fft_seq_ctrl #(
   parameter int N        = 128,
   parameter int FRAME_W  = 6,
   parameter int DLY      = 16,
   parameter int PIPE_LAT = 18,
   parameter int ADDR_W   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic              adv,
   output logic              zero_in,
   output logic              bfii_ctrl,
   output logic [ADDR_W-1:0] coeff0_addr,
   output logic              coeff0_en,
   output logic [ADDR_W-1:0] coeff1_addr,
   output logic              coeff1_en,
   output logic              out_valid,
   output logic              out_sof,
   output logic              busy
);

   localparam int DLY_W = $clog2(DLY);
   localparam int DRN_W = $clog2(PIPE_LAT);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [FRAME_W-1:0]  sample_cnt_q, sample_cnt_d;
   logic [DLY_W-1:0]    dly_cnt_q, dly_cnt_d;
   logic [DRN_W-1:0]    drain_cnt_q, drain_cnt_d;
   logic                bfii_q, bfii_d;
   logic [ADDR_W-1:0]   c0_addr_q, c0_addr_d;
   logic [ADDR_W-1:0]   c1_addr_q, c1_addr_d;
   logic                c1_en_q, c1_en_d;
   logic                c0_en_q, c0_en_d;
   logic                in_ready_q, in_ready_d;
   logic                zero_in_q, zero_in_d;
   logic                busy_q, busy_d;
   logic [PIPE_LAT-1:0] tag_v_q, tag_v_d;
   logic [PIPE_LAT-1:0] tag_s_q, tag_s_d;

   logic adv_c;
   logic accept_c;

   // Advance strobe and pipeline-tail markers (combinational on in_valid).
   always_comb begin
      accept_c  = in_valid & in_ready_q;
      adv_c     = (state_q == DRAIN) | accept_c;
      adv       = adv_c;
      out_valid = tag_v_q[PIPE_LAT-1] & adv_c;
      out_sof   = tag_s_q[PIPE_LAT-1] & adv_c;
   end

   // Next-state: FSM, counters, coefficient streams and valid-tag shift register.
   always_comb begin
      state_d     = state_q;
      sample_cnt_d = sample_cnt_q;
      dly_cnt_d   = dly_cnt_q;
      drain_cnt_d = drain_cnt_q;
      bfii_d      = bfii_q;
      c0_addr_d   = c0_addr_q;
      c1_addr_d   = c1_addr_q;
      c1_en_d     = c1_en_q;
      tag_v_d     = tag_v_q;
      tag_s_d     = tag_s_q;

      case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (flush) state_d = DRAIN;
         DRAIN: begin
            if (drain_cnt_q == DRN_W'(PIPE_LAT - 1)) state_d = IDLE;
            else drain_cnt_d = drain_cnt_q + DRN_W'(1);
         end
         default: state_d = IDLE;
      endcase

      if (adv_c) begin
         sample_cnt_d = (sample_cnt_q == FRAME_W'(N/2 - 1)) ? '0 : sample_cnt_q + FRAME_W'(1);
         dly_cnt_d    = (dly_cnt_q == DLY_W'(DLY - 1)) ? '0 : dly_cnt_q + DLY_W'(1);
         if (dly_cnt_q == DLY_W'(DLY - 1)) begin
            bfii_d  = ~bfii_q;
            c1_en_d = 1'b1;
         end
         c0_addr_d = sample_cnt_q[ADDR_W-1:0];
         // sample_cnt counts every advance since IDLE, so the DLY-advance lagged
         // copy of coeff0_addr is the counter minus DLY once DLY advances have passed.
         c1_addr_d = c1_en_q ? (sample_cnt_q[ADDR_W-1:0] - ADDR_W'(DLY)) : '0;
         tag_v_d   = {tag_v_q[PIPE_LAT-2:0], accept_c};
         tag_s_d   = {tag_s_q[PIPE_LAT-2:0], accept_c & (sample_cnt_q == '0)};
      end

      if (state_q == DRAIN && state_d == IDLE) begin
         sample_cnt_d = '0;
         dly_cnt_d    = '0;
         drain_cnt_d  = '0;
         bfii_d       = 1'b0;
         c0_addr_d    = '0;
         c1_addr_d    = '0;
         c1_en_d      = 1'b0;
         tag_v_d      = '0;
         tag_s_d      = '0;
      end

      in_ready_d = (state_d != DRAIN);
      zero_in_d  = (state_d == DRAIN);
      busy_d     = (state_d != IDLE);
      c0_en_d    = (state_d != IDLE);
   end

   // State and registered outputs; async reset returns everything to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sample_cnt_q <= '0;
         dly_cnt_q    <= '0;
         drain_cnt_q  <= '0;
         bfii_q       <= 1'b0;
         c0_addr_q    <= '0;
         c1_addr_q    <= '0;
         c1_en_q      <= 1'b0;
         c0_en_q      <= 1'b0;
         in_ready_q   <= 1'b1;
         zero_in_q    <= 1'b0;
         busy_q       <= 1'b0;
         tag_v_q      <= '0;
         tag_s_q      <= '0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         dly_cnt_q    <= dly_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         bfii_q       <= bfii_d;
         c0_addr_q    <= c0_addr_d;
         c1_addr_q    <= c1_addr_d;
         c1_en_q      <= c1_en_d;
         c0_en_q      <= c0_en_d;
         in_ready_q   <= in_ready_d;
         zero_in_q    <= zero_in_d;
         busy_q       <= busy_d;
         tag_v_q      <= tag_v_d;
         tag_s_q      <= tag_s_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign zero_in     = zero_in_q;
   assign busy        = busy_q;
   assign bfii_ctrl   = bfii_q;
   assign coeff0_addr = c0_addr_q;
   assign coeff0_en   = c0_en_q;
   assign coeff1_addr = c1_addr_q;
   assign coeff1_en   = c1_en_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Testbench for fft_seq_ctrl: negedge monitor with a behavioural model and an
// output scoreboard, plus one task per scenario.
`timescale 1ns/1ps
module tb_fft_seq_ctrl;

   localparam int N        = 128;
   localparam int FRAME_W  = 6;
   localparam int DLY      = 16;
   localparam int PIPE_LAT = 18;
   localparam int ADDR_W   = 6;

   logic              clk, rst, in_valid, flush;
   logic              in_ready, adv, zero_in, bfii_ctrl, coeff0_en, coeff1_en;
   logic              out_valid, out_sof, busy;
   logic [ADDR_W-1:0] coeff0_addr, coeff1_addr;

   fft_seq_ctrl #(.N(N), .FRAME_W(FRAME_W), .DLY(DLY), .PIPE_LAT(PIPE_LAT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .adv(adv), .zero_in(zero_in), .bfii_ctrl(bfii_ctrl),
      .coeff0_addr(coeff0_addr), .coeff0_en(coeff0_en),
      .coeff1_addr(coeff1_addr), .coeff1_en(coeff1_en),
      .out_valid(out_valid), .out_sof(out_sof), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
   typedef struct {logic sof; int due;} exp_t;

   exp_t    sb[$];
   int      hist[$];
   mstate_t ms;
   int      mcnt, madv, madv_idle, mdrain, mc0, mc1;
   logic    mbfii, mc1en;
   int      n_out, n_sof, n_nrdy, n_zin, first_acc, first_out;

   // Model of the sequencer; checks every output each cycle, then steps the model.
   always @(negedge clk) begin
      logic exp_adv, exp_ov, exp_sof;
      exp_t e;
      if (rst) begin
         ms = M_IDLE; mcnt = 0; madv = 0; madv_idle = 0; mdrain = 0;
         mc0 = 0; mc1 = 0; mbfii = 1'b0; mc1en = 1'b0;
         sb.delete(); hist.delete();
         for (int i = 0; i < DLY; i++) hist.push_back(0);
      end else begin
         exp_adv = (ms == M_DRAIN) || in_valid;
         checks++;
         if (adv !== exp_adv) begin
            errors++; $display("FAIL adv t=%0t got %b exp %b", $time, adv, exp_adv);
         end
         checks++;
         if ({in_ready, zero_in, busy, coeff0_en} !== {ms != M_DRAIN, ms == M_DRAIN, ms != M_IDLE, ms != M_IDLE}) begin
            errors++; $display("FAIL status t=%0t got rdy/zin/busy/c0en=%b exp %b", $time,
               {in_ready, zero_in, busy, coeff0_en}, {ms != M_DRAIN, ms == M_DRAIN, ms != M_IDLE, ms != M_IDLE});
         end
         checks++;
         if (bfii_ctrl !== mbfii) begin
            errors++; $display("FAIL bfii_ctrl t=%0t got %b exp %b", $time, bfii_ctrl, mbfii);
         end
         checks++;
         if (coeff0_addr !== ADDR_W'(mc0)) begin
            errors++; $display("FAIL coeff0_addr t=%0t got %0d exp %0d", $time, coeff0_addr, mc0);
         end
         checks++;
         if ({coeff1_en, coeff1_addr} !== {mc1en, ADDR_W'(mc1)}) begin
            errors++; $display("FAIL coeff1 t=%0t got en=%b addr=%0d exp en=%b addr=%0d", $time,
               coeff1_en, coeff1_addr, mc1en, mc1);
         end
         exp_ov = 1'b0; exp_sof = 1'b0;
         if (exp_adv && sb.size() > 0 && sb[0].due == madv) begin
            e = sb.pop_front();
            exp_ov = 1'b1; exp_sof = e.sof;
         end
         checks++;
         if ({out_valid, out_sof} !== {exp_ov, exp_sof}) begin
            errors++; $display("FAIL out t=%0t got valid/sof=%b%b exp %b%b", $time, out_valid, out_sof, exp_ov, exp_sof);
         end
         if (out_valid === 1'b1) begin
            n_out++;
            if (out_sof === 1'b1) n_sof++;
            if (first_out < 0) first_out = madv;
         end
         if (in_ready === 1'b0) n_nrdy++;
         if (zero_in === 1'b1) n_zin++;

         if (exp_adv) begin
            if (ms != M_DRAIN) begin
               sb.push_back('{sof: (mcnt == 0), due: madv + PIPE_LAT});
               if (first_acc < 0) first_acc = madv;
            end
            mc0 = mcnt;
            mcnt = (mcnt + 1) % (N/2);
            hist.push_back(mc0);
            mc1 = hist.pop_front();
            madv_idle++;
            mc1en = (madv_idle >= DLY);
            mbfii = ((madv_idle / DLY) % 2) == 1;
            madv++;
         end
         case (ms)
            M_IDLE: if (in_valid) ms = M_RUN;
            M_RUN:  if (flush) begin ms = M_DRAIN; mdrain = 0; end
            default: begin
               if (mdrain == PIPE_LAT - 1) begin
                  ms = M_IDLE; mcnt = 0; madv_idle = 0; mc0 = 0; mc1 = 0;
                  mbfii = 1'b0; mc1en = 1'b0;
                  hist.delete();
                  for (int i = 0; i < DLY; i++) hist.push_back(0);
                  checks++;
                  if (sb.size() != 0) begin
                     errors++; $display("FAIL drain_empty got %0d pending exp 0", sb.size());
                  end
               end else mdrain++;
            end
         endcase
      end
   end

   task automatic drive(input logic iv, input logic fl);
      @(posedge clk); #1;
      in_valid = iv; flush = fl;
   endtask

   task automatic clear_stats();
      n_out = 0; n_sof = 0; n_nrdy = 0; n_zin = 0; first_acc = -1; first_out = -1;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (busy === 1'b0) done = 1;
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL wait_idle timeout busy=%b exp 0", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      clear_stats();
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, busy, in_ready, bfii_ctrl, coeff0_addr, coeff1_addr, coeff0_en, coeff1_en, zero_in, adv}
          !== {1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_init got ov=%b busy=%b rdy=%b bfii=%b a0=%0d a1=%0d", out_valid, busy, in_ready, bfii_ctrl, coeff0_addr, coeff1_addr);
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0);
      @(posedge clk); #2;
      in_valid = 1'b0;
      checks++;
      if (coeff0_addr !== 6'd5) begin
         errors++; $display("FAIL pre_rst_addr got %0d exp 5", coeff0_addr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, busy, in_ready, bfii_ctrl, coeff0_addr, coeff1_addr, coeff0_en, zero_in}
          !== {1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_mid got ov=%b busy=%b rdy=%b bfii=%b a0=%0d a1=%0d c0en=%b", out_valid, busy, in_ready, bfii_ctrl, coeff0_addr, coeff1_addr, coeff0_en);
      end
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_continuous();
      clear_stats();
      for (int i = 0; i < 128; i++) drive(1'b1, i == 127);
      drive(1'b0, 1'b0);
      wait_idle();
      checks++;
      if (n_out != 128) begin errors++; $display("FAIL cont_count got %0d exp 128", n_out); end
      checks++;
      if (n_sof != 2) begin errors++; $display("FAIL cont_sof got %0d exp 2", n_sof); end
      checks++;
      if (first_out - first_acc != PIPE_LAT) begin
         errors++; $display("FAIL cont_latency got %0d exp %0d", first_out - first_acc, PIPE_LAT);
      end
   endtask

   task automatic test_stall();
      logic              b0;
      logic [ADDR_W-1:0] a0;
      clear_stats();
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      @(negedge clk);
      b0 = bfii_ctrl; a0 = coeff0_addr;
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if ({bfii_ctrl, coeff0_addr, adv} !== {b0, a0, 1'b0}) begin
         errors++; $display("FAIL stall_hold got bfii=%b addr=%0d adv=%b exp bfii=%b addr=%0d adv=0", bfii_ctrl, coeff0_addr, adv, b0, a0);
      end
      for (int i = 0; i < 10; i++) drive(1'b1, i == 9);
      drive(1'b0, 1'b0);
      wait_idle();
      checks++;
      if (n_out != 20) begin errors++; $display("FAIL stall_count got %0d exp 20", n_out); end
   endtask

   task automatic test_wrap();
      clear_stats();
      for (int i = 0; i < 70; i++) begin
         drive(1'b1, i == 69);
         if (i == 64) begin
            checks++;
            if (coeff0_addr !== 6'd63) begin errors++; $display("FAIL wrap_pre got %0d exp 63", coeff0_addr); end
         end
         if (i == 65) begin
            checks++;
            if (coeff0_addr !== 6'd0) begin errors++; $display("FAIL wrap_addr got %0d exp 0", coeff0_addr); end
         end
      end
      drive(1'b0, 1'b0);
      wait_idle();
      checks++;
      if ({n_out, n_sof} != {32'd70, 32'd2}) begin
         errors++; $display("FAIL wrap_out got out=%0d sof=%0d exp 70/2", n_out, n_sof);
      end
   endtask

   task automatic test_flush();
      clear_stats();
      for (int i = 0; i < 20; i++) drive(1'b1, i == 19);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);
      wait_idle();
      checks++;
      if (n_nrdy != PIPE_LAT) begin errors++; $display("FAIL flush_nrdy got %0d exp %0d", n_nrdy, PIPE_LAT); end
      checks++;
      if (n_zin != PIPE_LAT) begin errors++; $display("FAIL flush_zin got %0d exp %0d", n_zin, PIPE_LAT); end
      checks++;
      if (n_out != 20) begin errors++; $display("FAIL flush_count got %0d exp 20", n_out); end
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_idle got busy/rdy=%b exp 01", {busy, in_ready}); end
   endtask

   task automatic test_coeff1();
      clear_stats();
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, i == 39);
         checks++;
         if (coeff1_en !== (i >= DLY)) begin
            errors++; $display("FAIL coeff1_en adv=%0d got %b exp %b", i, coeff1_en, i >= DLY);
         end
         if (i == 32) begin
            checks++;
            if ({coeff0_addr, coeff1_addr} !== {6'd31, 6'd15}) begin
               errors++; $display("FAIL coeff1_lag got a0=%0d a1=%0d exp 31/15", coeff0_addr, coeff1_addr);
            end
         end
      end
      drive(1'b0, 1'b0);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_continuous();
      test_stall();
      test_wrap();
      test_flush();
      test_coeff1();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
